// File: rtl/pcie_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : pcie_tx_feeder
// Purpose  : Moves TLP beats from a first-word-fall-through XGMII-RX FIFO
//            into the PCIe core AXI4-Stream TX port through a single output
//            beat register. Gap words are dropped. TLPs longer than
//            MAX_BEATS are truncated and their tail is discarded.
// Ports    : clk, sys_rst_n           - clock, async active-low reset
//            dout[71:0], empty, rd_en - FIFO read side
//                                       dout: [63:0] data, [64] valid,
//                                       [65] last, [66] lo DW en,
//                                       [67] hi DW en
//            s_axis_tx_*              - AXI4-Stream master toward PCIe TX
//            err_pulse                - one-cycle pulse on gap-in-TLP or
//                                       length-guard trip
//            tlp_count, err_count     - statistics (tied to 0 unless the
//                                       TLP_COUNTER_EN macro is defined)
// Options  : `define TLP_COUNTER_EN enables the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_tx_feeder #(
  parameter logic [15:0] MAX_BEATS = 16'd130
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic [71:0] dout,
  input  logic        empty,
  output logic        rd_en,
  output logic [63:0] s_axis_tx_tdata,
  output logic [7:0]  s_axis_tx_tkeep,
  output logic        s_axis_tx_tlast,
  output logic        s_axis_tx_tvalid,
  output logic [3:0]  s_axis_tx_tuser,
  input  logic        s_axis_tx_tready,
  output logic        err_pulse,
  output logic [15:0] tlp_count,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic [63:0] tdata_q;
  logic [7:0]  tkeep_q;
  logic        tlast_q;
  logic        tvalid_q;
  logic        err_q, err_d;

  logic        w_word_valid;
  logic        w_word_last;
  logic        w_discard;
  logic        w_pop;
  logic        w_load;
  logic        w_guard_trip;
  logic [15:0] w_beat_num;
  logic        w_unused;

  assign w_word_valid = dout[64];
  assign w_word_last  = dout[65];
  // Upper FIFO bits carry nothing for this block.
  assign w_unused     = ^dout[71:68];

  // A word that will not become a beat may be popped even while the output
  // register is stalled, so gap/drop words never hold up the stream.
  assign w_discard = (state_q == DROP) || !w_word_valid;
  // Reset gates the pop combinationally so the FIFO is untouched while held.
  assign rd_en     = sys_rst_n && !empty &&
                     (!tvalid_q || s_axis_tx_tready || w_discard);
  assign w_pop     = rd_en;
  assign w_load    = w_pop && !w_discard;

  // Ordinal of the beat being loaded within its TLP (first beat is 1).
  assign w_beat_num   = (state_q == XFER) ? (beat_cnt_q + 16'd1) : 16'd1;
  assign w_guard_trip = w_load && !w_word_last && (w_beat_num >= MAX_BEATS);

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = 1'b0;
    if (w_pop) begin
      case (state_q)
        IDLE, XFER: begin
          if (w_word_valid) begin
            if (w_word_last) begin
              state_d    = IDLE;
              beat_cnt_d = 16'd0;
            end else if (w_guard_trip) begin
              state_d    = DROP;
              beat_cnt_d = 16'd0;
              err_d      = 1'b1;
            end else begin
              state_d    = XFER;
              beat_cnt_d = w_beat_num;
            end
          end else if (state_q == XFER) begin
            // Gap inside a TLP: drop it, flag it, keep the TLP going.
            err_d = 1'b1;
          end
        end
        DROP: begin
          if (w_word_last) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d    = IDLE;
          beat_cnt_d = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= 16'd0;
      tdata_q    <= 64'd0;
      tkeep_q    <= 8'd0;
      tlast_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      // Load takes priority: a pop in the same cycle as an accept replaces
      // the drained beat; otherwise an accept empties the register.
      if (w_load) begin
        tdata_q  <= dout[63:0];
        tkeep_q  <= {{4{dout[67]}}, {4{dout[66]}}};
        tlast_q  <= w_word_last || w_guard_trip;
        tvalid_q <= 1'b1;
      end else if (s_axis_tx_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign s_axis_tx_tdata  = tdata_q;
  assign s_axis_tx_tkeep  = tkeep_q;
  assign s_axis_tx_tlast  = tlast_q;
  assign s_axis_tx_tvalid = tvalid_q;
  assign s_axis_tx_tuser  = 4'h0;
  assign err_pulse        = err_q;

`ifdef TLP_COUNTER_EN
  logic [15:0] tlp_count_q;
  logic [7:0]  err_count_q;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tlp_count_q <= 16'd0;
      err_count_q <= 8'd0;
    end else begin
      if (tvalid_q && s_axis_tx_tready && tlast_q) begin
        tlp_count_q <= tlp_count_q + 16'd1;
      end
      if (err_q && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign tlp_count = tlp_count_q;
  assign err_count = err_count_q;
`else
  assign tlp_count = 16'd0;
  assign err_count = 8'd0;
`endif

endmodule
`default_nettype wire
